dcache_ctrl: RTL and testbench

- Direct-mapped, write-back, write-allocate data cache controller.
- Sits directly downstream of the CPU's MEM stage and replaces the single-cycle data memory port. It consumes the EX/MEM address, read-enable, write-enable and write data.
- On a hit it returns data in the same cycle. On a miss it stalls the pipeline and moves whole 4-word lines to and from a multi-cycle main memory.
- Also provides a flush sequence, used at halt, that writes every dirty line back to memory.

---
 rtl/cpu_pkg.sv | 34 +++
 rtl/dcache_ctrl_if.sv | 21 ++
 rtl/dcache_ctrl_cache_array.sv | 57 +++++
 rtl/dcache_ctrl.sv | 169 ++++++++++++++++
 tb/tb_dcache_ctrl.sv | 370 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared data-cache constants, FSM encoding and line word packing
package cpu_pkg;
    localparam int ADDR_W      = 16;
    localparam int WORD_W      = 16;
    localparam int LINE_WORDS  = 4;
    localparam int OFF_W       = 2;
    localparam int LINE_W      = WORD_W * LINE_WORDS;
    localparam int LADDR_W     = ADDR_W - OFF_W;
    // Memory may complete a request in the first cycle it is raised.
    localparam int MEM_MIN_LAT = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WB,
        ST_FILL,
        ST_FLUSH_SCAN,
        ST_FLUSH_WB
    } cache_state_e;

    // Word k of a line lives in bits [16k+15:16k].
    function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                    input logic [OFF_W-1:0] off);
        return line[int'(off)*WORD_W +: WORD_W];
    endfunction

    function automatic logic [LINE_W-1:0] line_put(input logic [LINE_W-1:0] line,
                                                   input logic [OFF_W-1:0] off,
                                                   input logic [WORD_W-1:0] word);
        logic [LINE_W-1:0] l;
        l = line;
        l[int'(off)*WORD_W +: WORD_W] = word;
        return l;
    endfunction
endpackage

// File: rtl/dcache_ctrl_if.sv
// rtl/dcache_ctrl_if.sv - line-granular bus between the data cache and main memory
interface dcache_ctrl_if;
    import cpu_pkg::*;

    logic [LADDR_W-1:0] mem_addr;
    logic               mem_re;
    logic               mem_we;
    logic [LINE_W-1:0]  mem_wdata;
    logic [LINE_W-1:0]  mem_rdata;
    logic               mem_rdy;

    modport master (
        output mem_addr, mem_re, mem_we, mem_wdata,
        input  mem_rdata, mem_rdy
    );

    modport slave (
        input  mem_addr, mem_re, mem_we, mem_wdata,
        output mem_rdata, mem_rdy
    );
endinterface

// File: rtl/dcache_ctrl_cache_array.sv
// rtl/dcache_ctrl_cache_array.sv - valid/dirty/tag/data storage, one combinational read port
module cache_array
    import cpu_pkg::*;
#(
    parameter int NUM_LINES = 8,
    parameter int IDX_W     = $clog2(NUM_LINES),
    parameter int TAG_W     = LADDR_W - IDX_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  idx,
    output logic              rd_valid,
    output logic              rd_dirty,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [LINE_W-1:0] rd_line,
    input  logic              wr_en,
    input  logic [OFF_W-1:0]  wr_off,
    input  logic [WORD_W-1:0] wr_word,
    input  logic              fill_en,
    input  logic [TAG_W-1:0]  fill_tag,
    input  logic [LINE_W-1:0] fill_line,
    input  logic              clean_en
);
    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [LINE_W-1:0]    data_q [NUM_LINES];

    assign rd_valid = valid_q[idx];
    assign rd_dirty = dirty_q[idx];
    assign rd_tag   = tag_q[idx];
    assign rd_line  = data_q[idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_en) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
        end else if (wr_en) begin
            dirty_q[idx] <= 1'b1;
        end else if (clean_en) begin
            dirty_q[idx] <= 1'b0;
        end
    end

    // Tag and data are meaningless until valid is set, so they carry no reset.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[idx]  <= fill_tag;
            data_q[idx] <= fill_line;
        end else if (wr_en) begin
            data_q[idx] <= line_put(data_q[idx], wr_off, wr_word);
        end
    end
endmodule

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-back write-allocate data cache controller
module dcache_ctrl
    import cpu_pkg::*;
#(
    parameter int NUM_LINES = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic                cpu_re,
    input  logic                cpu_we,
    input  logic [WORD_W-1:0]   cpu_wdata,
    output logic [WORD_W-1:0]   cpu_rdata,
    output logic                cpu_stall,
    input  logic                flush,
    output logic                flush_done,
    dcache_ctrl_if.master       mem
);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = LADDR_W - IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = {IDX_W{1'b1}};

    cache_state_e        state_q, state_d;
    logic [IDX_W-1:0]    cnt_q, cnt_d;
    logic [LADDR_W-1:0]  maddr_q, maddr_d;
    logic [LINE_W-1:0]   mwdata_q, mwdata_d;
    logic [WORD_W-1:0]   rdata_q, rdata_d;

    logic [OFF_W-1:0]    cpu_off;
    logic [IDX_W-1:0]    cpu_idx;
    logic [TAG_W-1:0]    cpu_tag;
    logic [IDX_W-1:0]    arr_idx;
    logic                flushing, req, hit;
    logic                rd_valid, rd_dirty;
    logic [TAG_W-1:0]    rd_tag;
    logic [LINE_W-1:0]   rd_line;
    logic                wr_en, fill_en, clean_en, stall;

    assign cpu_off  = cpu_addr[OFF_W-1:0];
    assign cpu_idx  = cpu_addr[IDX_W+OFF_W-1:OFF_W];
    assign cpu_tag  = cpu_addr[ADDR_W-1:IDX_W+OFF_W];
    assign flushing = (state_q == ST_FLUSH_SCAN) || (state_q == ST_FLUSH_WB);
    // The single read port follows the scan counter during a flush, the CPU otherwise.
    assign arr_idx  = flushing ? cnt_q : cpu_idx;
    assign req      = cpu_re | cpu_we;
    assign hit      = rd_valid && (rd_tag == cpu_tag) && req;

    cache_array #(
        .NUM_LINES (NUM_LINES),
        .IDX_W     (IDX_W),
        .TAG_W     (TAG_W)
    ) u_array (
        .clk       (clk),
        .rst       (rst),
        .idx       (arr_idx),
        .rd_valid  (rd_valid),
        .rd_dirty  (rd_dirty),
        .rd_tag    (rd_tag),
        .rd_line   (rd_line),
        .wr_en     (wr_en),
        .wr_off    (cpu_off),
        .wr_word   (cpu_wdata),
        .fill_en   (fill_en),
        .fill_tag  (cpu_tag),
        .fill_line (mem.mem_rdata),
        .clean_en  (clean_en)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            maddr_q  <= '0;
            mwdata_q <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            maddr_q  <= maddr_d;
            mwdata_q <= mwdata_d;
            rdata_q  <= rdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        maddr_d    = maddr_q;
        mwdata_d   = mwdata_q;
        rdata_d    = rdata_q;
        wr_en      = 1'b0;
        fill_en    = 1'b0;
        clean_en   = 1'b0;
        stall      = 1'b0;
        flush_done = 1'b0;
        mem.mem_re = 1'b0;
        mem.mem_we = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req && !hit) begin
                    stall = 1'b1;
                    if (rd_valid && rd_dirty) begin
                        state_d  = ST_WB;
                        maddr_d  = {rd_tag, cpu_idx};
                        mwdata_d = rd_line;
                    end else begin
                        state_d  = ST_FILL;
                        maddr_d  = cpu_addr[ADDR_W-1:OFF_W];
                    end
                end else begin
                    if (hit) begin
                        if (cpu_we) wr_en = 1'b1;
                        else        rdata_d = line_word(rd_line, cpu_off);
                    end
                    if (flush) begin
                        state_d = ST_FLUSH_SCAN;
                        cnt_d   = '0;
                    end
                end
            end
            ST_WB: begin
                stall      = 1'b1;
                mem.mem_we = 1'b1;
                if (mem.mem_rdy) begin
                    clean_en = 1'b1;
                    state_d  = ST_FILL;
                    maddr_d  = cpu_addr[ADDR_W-1:OFF_W];
                end
            end
            ST_FILL: begin
                stall      = 1'b1;
                mem.mem_re = 1'b1;
                if (mem.mem_rdy) begin
                    fill_en = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_FLUSH_SCAN: begin
                stall = 1'b1;
                if (rd_dirty) begin
                    state_d  = ST_FLUSH_WB;
                    maddr_d  = {rd_tag, cnt_q};
                    mwdata_d = rd_line;
                end else if (cnt_q == LAST_IDX) begin
                    flush_done = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_FLUSH_WB: begin
                // Returns to the same index, which now scans clean and advances.
                stall      = 1'b1;
                mem.mem_we = 1'b1;
                if (mem.mem_rdy) begin
                    clean_en = 1'b1;
                    state_d  = ST_FLUSH_SCAN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A miss seen while rst is high must not stall the pipeline.
    assign cpu_stall     = stall && !rst;
    assign cpu_rdata     = rdata_d;
    assign mem.mem_addr  = maddr_q;
    assign mem.mem_wdata = mwdata_q;
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - randomized bench for dcache_ctrl against a flat-memory reference
module tb_dcache_ctrl;
    import cpu_pkg::*;

    localparam int NL = 8;

    typedef struct packed {
        logic        we;
        logic [13:0] addr;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_re, cpu_we, cpu_stall, flush, flush_done;

    dcache_ctrl_if mem_bus ();

    dcache_ctrl #(.NUM_LINES(NL)) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_addr   (cpu_addr),
        .cpu_re     (cpu_re),
        .cpu_we     (cpu_we),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .flush      (flush),
        .flush_done (flush_done),
        .mem        (mem_bus)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    txn_t        log_q[$];
    txn_t        exp_q[$];
    logic [63:0] pre_mem [int];
    logic [63:0] bmem [int];
    logic [15:0] ref_mem [int];
    bit          m_valid [NL];
    bit          m_dirty [NL];
    logic [10:0] m_tag [NL];
    int          force_lat = -1;
    bit          spur_req = 1'b0;
    logic [15:0] last_rd = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] init_word(input logic [15:0] a);
        return (a * 16'h9e37) ^ 16'h5a3c;
    endfunction

    function automatic logic [63:0] orig_line(input logic [13:0] la);
        if (pre_mem.exists(int'(la))) return pre_mem[int'(la)];
        return {init_word({la, 2'd3}), init_word({la, 2'd2}), init_word({la, 2'd1}), init_word({la, 2'd0})};
    endfunction

    function automatic logic [63:0] bank_line(input logic [13:0] la);
        if (bmem.exists(int'(la))) return bmem[int'(la)];
        return orig_line(la);
    endfunction

    function automatic logic [15:0] ref_word(input logic [15:0] a);
        logic [63:0] l;
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        l = orig_line(a[15:2]);
        return l[int'(a[1:0])*16 +: 16];
    endfunction

    // Main memory: accepts one line request at a time and completes it after a delay.
    initial begin : mem_model
        bit          busy;
        int          wait_n;
        txn_t        cur;
        logic [63:0] cur_wd;
        busy = 1'b0;
        wait_n = 0;
        mem_bus.mem_rdy = 1'b0;
        mem_bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_bus.mem_rdy = 1'b0;
            #1;
            if (rst) begin
                busy = 1'b0;
            end else begin
                if (!busy && (mem_bus.mem_re || mem_bus.mem_we)) begin
                    check("mem_excl", 64'(mem_bus.mem_re & mem_bus.mem_we), 64'd0);
                    cur.we = mem_bus.mem_we;
                    cur.addr = mem_bus.mem_addr;
                    cur_wd = mem_bus.mem_wdata;
                    log_q.push_back(cur);
                    busy = 1'b1;
                    wait_n = (force_lat >= 0) ? force_lat : $urandom_range(MEM_MIN_LAT, 2);
                end
                if (busy) begin
                    if (wait_n == 0) begin
                        check("mem_hold_addr", 64'(mem_bus.mem_addr), 64'(cur.addr));
                        if (cur.we) begin
                            check("mem_hold_wdata", mem_bus.mem_wdata, cur_wd);
                            bmem[int'(cur.addr)] = mem_bus.mem_wdata;
                        end else begin
                            mem_bus.mem_rdata = bank_line(cur.addr);
                        end
                        mem_bus.mem_rdy = 1'b1;
                        busy = 1'b0;
                    end else begin
                        wait_n--;
                    end
                end else if (spur_req) begin
                    mem_bus.mem_rdata = {$urandom, $urandom};
                    mem_bus.mem_rdy = 1'b1;
                    spur_req = 1'b0;
                end
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < NL; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        last_rd = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        cpu_re = 1'b0;
        cpu_we = 1'b0;
        flush = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        log_q.delete();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cpu_re = 1'b0;
            cpu_we = 1'b0;
            #1;
            check("rd_hold", 64'(cpu_rdata), 64'(last_rd));
        end
    endtask

    task automatic cpu_op(input bit re, input bit we, input logic [15:0] a,
                          input logic [15:0] wd, output int stalls);
        int   idx;
        bit   exp_hit;
        bit   to;
        txn_t t;
        idx = int'(a[4:2]);
        to = 1'b0;
        exp_q.delete();
        exp_hit = m_valid[idx] && (m_tag[idx] == a[15:5]);
        if (!exp_hit) begin
            if (m_valid[idx] && m_dirty[idx]) begin
                t.we = 1'b1;
                t.addr = {m_tag[idx], a[4:2]};
                exp_q.push_back(t);
            end
            t.we = 1'b0;
            t.addr = a[15:2];
            exp_q.push_back(t);
            m_valid[idx] = 1'b1;
            m_tag[idx] = a[15:5];
            m_dirty[idx] = 1'b0;
        end
        if (we) begin
            m_dirty[idx] = 1'b1;
            ref_mem[int'(a)] = wd;
        end
        @(negedge clk);
        cpu_addr = a;
        cpu_re = re;
        cpu_we = we;
        cpu_wdata = wd;
        #1;
        stalls = 0;
        while (cpu_stall && !to) begin
            stalls++;
            if (stalls > 60) to = 1'b1;
            else begin
                @(negedge clk);
                #1;
            end
        end
        check("op_bound", 64'(to), 64'd0);
        check("op_hit", 64'(stalls == 0), 64'(exp_hit));
        if (re && !we) begin
            check("op_rdata", 64'(cpu_rdata), 64'(ref_word(a)));
            last_rd = ref_word(a);
        end
        check("op_txn_n", 64'(log_q.size()), 64'(exp_q.size()));
        foreach (exp_q[i]) if (i < log_q.size()) check("op_txn", 64'(log_q[i]), 64'(exp_q[i]));
        log_q.delete();
    endtask

    task automatic do_flush(input int exp_cycles);
        int          n;
        int          dones;
        int          nbad;
        bit          to;
        bit          stall_low;
        txn_t        t;
        logic [63:0] l;
        n = 0;
        dones = 0;
        nbad = 0;
        to = 1'b0;
        stall_low = 1'b0;
        exp_q.delete();
        for (int i = 0; i < NL; i++) begin
            if (m_dirty[i]) begin
                t.we = 1'b1;
                t.addr = {m_tag[i], 3'(i)};
                exp_q.push_back(t);
                m_dirty[i] = 1'b0;
            end
        end
        @(negedge clk);
        cpu_re = 1'b0;
        cpu_we = 1'b0;
        flush = 1'b1;
        #1;
        while (!to) begin
            @(negedge clk);
            flush = 1'b0;
            #1;
            n++;
            if (!cpu_stall) stall_low = 1'b1;
            if (flush_done) begin
                dones++;
                break;
            end
            if (n > 300) to = 1'b1;
        end
        check("flush_bound", 64'(to), 64'd0);
        check("flush_stall", 64'(stall_low), 64'd0);
        if (exp_cycles >= 0) check("flush_cycles", 64'(n), 64'(exp_cycles));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            if (flush_done) dones++;
            check("flush_after_stall", 64'(cpu_stall), 64'd0);
        end
        check("flush_done_once", 64'(dones), 64'd1);
        check("flush_txn_n", 64'(log_q.size()), 64'(exp_q.size()));
        foreach (exp_q[i]) if (i < log_q.size()) check("flush_txn", 64'(log_q[i]), 64'(exp_q[i]));
        log_q.delete();
        foreach (ref_mem[k]) begin
            l = bank_line(14'(k >> 2));
            if (l[(k % 4)*16 +: 16] !== ref_mem[k]) nbad++;
        end
        check("flush_mem", 64'(nbad), 64'd0);
    endtask

    initial begin : main
        int          s;
        logic [63:0] l;
        logic [15:0] a;
        int          r;
        rst = 1'b1;
        cpu_addr = '0;
        cpu_re = 1'b0;
        cpu_we = 1'b0;
        cpu_wdata = '0;
        flush = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check("rst_stall", 64'(cpu_stall), 64'd0);
        check("rst_rdata", 64'(cpu_rdata), 64'd0);
        check("rst_flush_done", 64'(flush_done), 64'd0);
        check("rst_mem_re", 64'(mem_bus.mem_re), 64'd0);
        check("rst_mem_we", 64'(mem_bus.mem_we), 64'd0);
        check("rst_mem_addr", 64'(mem_bus.mem_addr), 64'd0);
        check("rst_mem_wdata", mem_bus.mem_wdata, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // cold miss, reread, dirty eviction, write allocate at minimum memory latency
        pre_mem[4] = 64'hDDDD_CCCC_BBBB_AAAA;
        force_lat = 0;
        cpu_op(1'b1, 1'b0, 16'h0013, 16'h0, s);
        check("cold_penalty", 64'(s), 64'd2);
        check("cold_rdata", 64'(cpu_rdata), 64'hDDDD);
        cpu_op(1'b1, 1'b0, 16'h0010, 16'h0, s);
        check("reread_stall", 64'(s), 64'd0);
        check("reread_rdata", 64'(cpu_rdata), 64'hAAAA);
        cpu_op(1'b0, 1'b1, 16'h0013, 16'h1234, s);
        check("wr_hit_stall", 64'(s), 64'd0);
        cpu_op(1'b1, 1'b0, 16'h0033, 16'h0, s);
        check("dirty_penalty", 64'(s), 64'd3);
        l = bmem[4];
        check("evict_word", 64'(l[63:48]), 64'h1234);
        cpu_op(1'b0, 1'b1, 16'h0100, 16'h5555, s);
        idle(1);
        cpu_op(1'b1, 1'b0, 16'h0100, 16'h0, s);
        check("wmiss_rdata", 64'(cpu_rdata), 64'h5555);
        force_lat = -1;
        do_flush(-1);

        // ordered flush of lines 1 and 4, then an all-clean flush
        do_reset();
        cpu_op(1'b0, 1'b1, 16'h0004, 16'h0a0a, s);
        cpu_op(1'b0, 1'b1, 16'h0010, 16'h0b0b, s);
        idle(1);
        do_flush(-1);
        do_flush(8);

        // reset while a fill is outstanding
        do_reset();
        force_lat = 6;
        @(negedge clk);
        cpu_addr = 16'h0200;
        cpu_re = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rmf_re_before", 64'(mem_bus.mem_re), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rmf_re", 64'(mem_bus.mem_re), 64'd0);
        check("rmf_we", 64'(mem_bus.mem_we), 64'd0);
        check("rmf_stall", 64'(cpu_stall), 64'd0);
        model_reset();
        @(negedge clk);
        cpu_re = 1'b0;
        #3;
        rst = 1'b0;
        log_q.delete();
        force_lat = -1;
        cpu_op(1'b1, 1'b0, 16'h0200, 16'h0, s);

        // spurious completion while idle must not disturb state or contents
        idle(1);
        spur_req = 1'b1;
        idle(3);
        check("spur_quiet", 64'({mem_bus.mem_re, mem_bus.mem_we, cpu_stall}), 64'd0);
        cpu_op(1'b1, 1'b0, 16'h0200, 16'h0, s);

        // random traffic over a few conflicting tags
        for (int i = 0; i < 400; i++) begin
            a = 16'($urandom_range(0, 127));
            if ($urandom_range(0, 7) == 0) a[15:12] = 4'($urandom);
            r = $urandom_range(0, 9);
            if (r < 5)      cpu_op(1'b1, 1'b0, a, 16'h0, s);
            else if (r < 9) cpu_op(1'b0, 1'b1, a, 16'($urandom), s);
            else            cpu_op(1'b1, 1'b1, a, 16'($urandom), s);
            idle($urandom_range(0, 2));
            if (i % 100 == 99) do_flush(-1);
        end
        do_flush(-1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
